// File: rtl/nibble_logic_unit.sv
// nibble_logic_unit: applies a bitwise logic operation (AND/OR/XOR/NOR) to two
// 32-bit operands, producing the result one nibble per cycle, LSB nibble first.
// Operands and opcode are captured when a start is accepted in IDLE, so the
// inputs may change freely while an operation is in flight.
module nibble_logic_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    op_e         op_q;
    logic [31:0] result_q;
    logic        busy_q;
    logic        done_q;
    logic        zero_q;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  nib_res;
    logic [31:0] result_d;

    // Compute the nibble selected by the counter and merge it into the result.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        nib_res  = 4'h0;
        nib_a    = a_q[{cnt_q, 2'b00} +: 4];
        nib_b    = b_q[{cnt_q, 2'b00} +: 4];
        case (op_q)
            OP_AND:  nib_res = nib_a & nib_b;
            OP_OR:   nib_res = nib_a | nib_b;
            OP_XOR:  nib_res = nib_a ^ nib_b;
            OP_NOR:  nib_res = ~(nib_a | nib_b);
            default: nib_res = 4'h0;
        endcase
        result_d = result_q;
        result_d[{cnt_q, 2'b00} +: 4] = nib_res;
    end

    // Control FSM with registered outputs; reset aborts any operation at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            op_q     <= OP_AND;
            result_q <= 32'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= in1;
                        b_q      <= in2;
                        op_q     <= op_e'(op);
                        result_q <= 32'h0;
                        cnt_q    <= 3'd0;
                        zero_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    cnt_q    <= cnt_q + 3'd1;
                    // Last nibble: leave RUN so the 3-bit counter never starts a second pass.
                    if (cnt_q == 3'd7) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        zero_q  <= (result_d == 32'h0);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Start is not looked at here; a request must wait for IDLE.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_logic_unit.sv
// Testbench for nibble_logic_unit: directed scenarios plus randomized operations,
// checked against a whole-word bitwise reference model.
module tb_nibble_logic_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int tests = 0;
    int fails = 0;

    nibble_logic_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .in1    (in1),
        .in2    (in2),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: the whole 32-bit word result of the selected operation.
    function automatic logic [31:0] ref_word(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Bits written after k nibble steps (low 4k bits).
    function automatic logic [31:0] low_mask(input int k);
        logic [63:0] m;
        m = (64'd1 << (4 * k)) - 64'd1;
        return m[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full operation: start edge, 8 RUN edges, DONE cycle, and two IDLE cycles.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input bit hold_start, input int change_at,
                          input logic [31:0] new_a);
        int busy_cnt;
        int done_cnt;
        in1   = a;
        in2   = b;
        op    = o;
        start = 1'b1;
        step();
        check({tag, ".start_busy"}, busy, 1'b1);
        check({tag, ".start_done"}, done, 1'b0);
        check({tag, ".start_result"}, result, 32'h0);
        check({tag, ".start_zero"}, zero, 1'b0);
        if (!hold_start) start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k - 1 == change_at) begin
                in1 = new_a;
                in2 = ~in2;
                op  = ~op;
            end
            step();
            check($sformatf("%s.partial%0d", tag, k), result, exp & low_mask(k));
            if (done) done_cnt++;
            if (k < 8) begin
                check($sformatf("%s.run_busy%0d", tag, k), busy, 1'b1);
                if (busy) busy_cnt++;
            end
        end
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".done_busy"}, busy, 1'b0);
        check({tag, ".zero"}, zero, (exp == 32'h0));
        check({tag, ".busy_cycles"}, busy_cnt, 8);
        // Exit DONE; in hold mode start is still high here and must be ignored.
        step();
        if (done) done_cnt++;
        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".post_done"}, done, 1'b0);
        check({tag, ".post_busy"}, busy, 1'b0);
        check({tag, ".post_result"}, result, exp);
        check({tag, ".post_zero"}, zero, (exp == 32'h0));
        start = 1'b0;
        step();
        check({tag, ".idle_busy"}, busy, 1'b0);
        check({tag, ".idle_result"}, result, exp);
        check({tag, ".idle_zero"}, zero, (exp == 32'h0));
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          dcount;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        in1   = 32'h0;
        in2   = 32'h0;
        #2;
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.result", result, 32'h0);
        check("reset.zero", zero, 1'b0);
        step();
        reset = 1'b0;
        step();
        check("idle.busy", busy, 1'b0);

        run_op("nor_ones", 2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, -1, 32'h0);
        run_op("nor_zero", 2'b11, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b0, -1, 32'h0);
        run_op("and_chg", 2'b00, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1'b0, 3, 32'h0);
        run_op("xor_hold", 2'b10, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b1, -1, 32'h0);

        // Reset after three RUN edges of an OR operation.
        in1   = 32'h1111_2222;
        in2   = 32'h4444_8888;
        op    = 2'b01;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("abort.partial3", result, 32'h0000_0AAA);
        #2;
        reset = 1'b1;
        #1;
        check("abort.busy", busy, 1'b0);
        check("abort.result", result, 32'h0);
        check("abort.done", done, 1'b0);
        check("abort.zero", zero, 1'b0);
        step();
        reset  = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) dcount++;
        end
        check("abort.no_done", dcount, 0);
        run_op("or_after_reset", 2'b01, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, -1, 32'h0);

        // Randomized operations, some with operand changes mid-RUN.
        for (int i = 0; i < 20; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (i % 5 == 0) ? ~r_a : $urandom;
            run_op($sformatf("rand%0d", i), r_op, r_a, r_b, ref_word(r_op, r_a, r_b),
                   ($urandom_range(0, 1) == 1), int'($urandom_range(0, 9)) - 1, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
